// File: rtl/shift_frame_sequencer_pkg.sv
// Shared encodings for the shift frame sequencer: shift-register ctrl codes,
// FSM states and a counter-width helper.
package shift_frame_sequencer_pkg;

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_SHL  = 2'b01;
    localparam logic [1:0] CTRL_SHR  = 2'b10;
    localparam logic [1:0] CTRL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_frame_sequencer_tick.sv
// Shift-rate divider: one tick every DIV enabled cycles; restarts from zero
// each time enable drops so every frame sees the same strobe phase.
module shift_tick_gen
    import shift_frame_sequencer_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = cnt_width(DIV);
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (!enable || (div_cnt == TC)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign tick = enable && (div_cnt == TC);

endmodule

// File: rtl/shift_frame_sequencer.sv
// Frame sequencer feeding a universal shift register: accepts a word, loads it,
// then issues N shift commands at one per DIV cycles and pulses frame_done.
module shift_frame_sequencer
    import shift_frame_sequencer_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         dir,
    input  logic         fill,
    output logic [1:0]   ctrl,
    output logic [N-1:0] d,
    output logic         bit_strobe,
    output logic         busy,
    output logic         frame_done
);

    localparam int unsigned BW = cnt_width(N);
    localparam logic [BW-1:0] BIT_TC = BW'(N - 1);

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    word;
    logic            dir_q;
    logic            fill_q;
    logic [BW-1:0]   bit_cnt;
    logic            tick;
    logic            accept;

    logic [1:0]      ctrl_c;
    logic [N-1:0]    d_c;
    logic            ready_c;
    logic            strobe_c;
    logic            busy_c;
    logic            done_c;

    shift_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (state == SHIFT),
        .tick   (tick)
    );

    assign accept = din_valid && (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame context is captured only on accept so mid-frame input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word   <= '0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
        end else if (accept) begin
            word   <= din;
            dir_q  <= dir;
            fill_q <= fill;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
        end else if (state == LOAD) begin
            bit_cnt <= '0;
        end else if (tick) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        ctrl_c    = CTRL_HOLD;
        d_c       = '0;
        ready_c   = 1'b0;
        strobe_c  = 1'b0;
        busy_c    = 1'b1;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                busy_c  = 1'b0;
                if (din_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ctrl_c    = CTRL_LOAD;
                d_c       = word;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    strobe_c = 1'b1;
                    ctrl_c   = dir_q ? CTRL_SHR : CTRL_SHL;
                    d_c      = N'(fill_q);
                    if (bit_cnt == BIT_TC) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ctrl       = ctrl_c;
    assign d          = d_c;
    assign din_ready  = ready_c;
    assign bit_strobe = strobe_c;
    assign busy       = busy_c;
    assign frame_done = done_c;

endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Bench for shift_frame_sequencer: two instances (DIV=4 and DIV=1) share the
// data inputs; traces are compared against a cycle-indexed frame model.
module tb_shift_frame_sequencer;

    localparam int unsigned N = 8;
    localparam int VW = N + 6;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] din;
    logic         dir;
    logic         fill;

    logic         din_valid0, din_ready0, bit_strobe0, busy0, frame_done0;
    logic [1:0]   ctrl0;
    logic [N-1:0] d0;
    logic         din_valid1, din_ready1, bit_strobe1, busy1, frame_done1;
    logic [1:0]   ctrl1;
    logic [N-1:0] d1;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] q_model;

    shift_frame_sequencer #(.N(N), .DIV(4)) u_dut0 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid0),
        .din_ready(din_ready0), .dir(dir), .fill(fill), .ctrl(ctrl0), .d(d0),
        .bit_strobe(bit_strobe0), .busy(busy0), .frame_done(frame_done0)
    );

    shift_frame_sequencer #(.N(N), .DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid1),
        .din_ready(din_ready1), .dir(dir), .fill(fill), .ctrl(ctrl1), .d(d1),
        .bit_strobe(bit_strobe1), .busy(busy1), .frame_done(frame_done1)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {ctrl, d, bit_strobe, busy, frame_done, din_ready}.
    function automatic logic [VW-1:0] obs(input bit sel);
        if (sel) return {ctrl1, d1, bit_strobe1, busy1, frame_done1, din_ready1};
        return {ctrl0, d0, bit_strobe0, busy0, frame_done0, din_ready0};
    endfunction

    localparam logic [VW-1:0] IDLE_VEC = {2'b00, {N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1};

    // Expected outputs t cycles after the accepting edge.
    function automatic logic [VW-1:0] exp_vec(input int t, input int div,
                                              input logic [N-1:0] w, input logic dr, input logic fl);
        int last_shift = N * div + 1;
        if (t == 1) return {2'b11, w, 1'b0, 1'b1, 1'b0, 1'b0};
        if (t <= last_shift) begin
            if (((t - 1) % div) == 0)
                return {(dr ? 2'b10 : 2'b01), N'(fl), 1'b1, 1'b1, 1'b0, 1'b0};
            return {2'b00, {N{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0};
        end
        if (t == last_shift + 1) return {2'b00, {N{1'b0}}, 1'b0, 1'b1, 1'b1, 1'b0};
        return IDLE_VEC;
    endfunction

    // Register contents after k shifts of word w.
    function automatic logic [N-1:0] exp_q(input logic [N-1:0] w, input logic dr,
                                           input logic fl, input int k);
        logic [N-1:0] ones = '1;
        if (!dr) return (w << k) | (fl ? ~(ones << k) : {N{1'b0}});
        return (w >> k) | (fl ? ~(ones >> k) : {N{1'b0}});
    endfunction

    task automatic set_valid(input bit sel, input logic v);
        if (sel) din_valid1 = v;
        else     din_valid0 = v;
    endtask

    task automatic start(input bit sel, input logic [N-1:0] w, input logic dr, input logic fl);
        logic [VW-1:0] o = obs(sel);
        checks++;
        if (o[0] !== 1'b1) begin
            errors++;
            $display("FAIL start_ready sel=%0d got=%b expected=1", sel, o[0]);
        end
        din = w; dir = dr; fill = fl;
        set_valid(sel, 1'b1);
    endtask

    // mode 0: plain, 1: disturb inputs while busy, 2: keep din_valid high.
    task automatic frame_body(input bit sel, input logic [N-1:0] w, input logic dr,
                              input logic fl, input int mode, input int stop_t);
        int div = sel ? 1 : 4;
        int k = 0;
        int tend = N * div + 3;
        logic [VW-1:0] o, e;
        for (int t = 1; t <= tend; t++) begin
            @(negedge clk);
            o = obs(sel);
            e = exp_vec(t, div, w, dr, fl);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL frame_trace sel=%0d t=%0d got=%h expected=%h (ctrl,d,strobe,busy,done,ready)",
                         sel, t, o, e);
            end
            case (o[VW-1:VW-2])
                2'b11: q_model = o[N+3:4];
                2'b01: q_model = {q_model[N-2:0], o[4]};
                2'b10: q_model = {o[4], q_model[N-1:1]};
                default: ;
            endcase
            if (o[VW-1:VW-2] == 2'b01 || o[VW-1:VW-2] == 2'b10) begin
                k++;
                checks++;
                if (q_model !== exp_q(w, dr, fl, k)) begin
                    errors++;
                    $display("FAIL q_step sel=%0d shift=%0d got=%h expected=%h",
                             sel, k, q_model, exp_q(w, dr, fl, k));
                end
            end
            if (mode == 1) begin
                if (t < tend - 1) begin
                    din = N'($urandom); dir = 1'($urandom); fill = 1'($urandom);
                    set_valid(sel, 1'b1);
                end else begin
                    set_valid(sel, 1'b0);
                end
            end else if (mode == 0 && t == 1) begin
                set_valid(sel, 1'b0);
            end
            if (t == stop_t) return;
        end
        checks++;
        if (k != N) begin
            errors++;
            $display("FAIL shift_count sel=%0d got=%0d expected=%0d", sel, k, N);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        din = '0; dir = 1'b0; fill = 1'b0;
        din_valid0 = 1'b0; din_valid1 = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs(1'(s)) !== IDLE_VEC) begin
                errors++;
                $display("FAIL reset_state sel=%0d got=%h expected=%h", s, obs(1'(s)), IDLE_VEC);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_left_div4();
        start(1'b0, 8'hA5, 1'b0, 1'b0);
        frame_body(1'b0, 8'hA5, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_right_div1();
        start(1'b1, 8'h0F, 1'b1, 1'b1);
        frame_body(1'b1, 8'h0F, 1'b1, 1'b1, 0, 0);
    endtask

    task automatic test_back_to_back();
        start(1'b0, 8'h3C, 1'b1, 1'b0);
        frame_body(1'b0, 8'h3C, 1'b1, 1'b0, 2, 0);
        din = 8'hC3;
        frame_body(1'b0, 8'hC3, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_busy_ignore();
        logic [N-1:0] w = N'($urandom);
        logic dr = 1'($urandom);
        logic fl = 1'($urandom);
        start(1'b0, w, dr, fl);
        frame_body(1'b0, w, dr, fl, 1, 0);
        @(negedge clk);
        checks++;
        if (obs(1'b0) !== IDLE_VEC) begin
            errors++;
            $display("FAIL no_extra_accept got=%h expected=%h", obs(1'b0), IDLE_VEC);
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] o;
        start(1'b0, 8'h96, 1'b0, 1'b1);
        frame_body(1'b0, 8'h96, 1'b0, 1'b1, 0, 13);
        #2 reset = 1'b0;
        #1;
        o = obs(1'b0);
        checks++;
        if (o !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_mid_async got=%h expected=%h", o, IDLE_VEC);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (frame_done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done got done=%b busy=%b expected done=0 busy=0",
                     frame_done0, busy0);
        end
    endtask

    task automatic test_reset_release();
        start(1'b0, 8'h6B, 1'b1, 1'b0);
        #2 reset = 1'b1;
        frame_body(1'b0, 8'h6B, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            bit sel = 1'($urandom);
            logic [N-1:0] w = N'($urandom);
            logic dr = 1'($urandom);
            logic fl = 1'($urandom);
            start(sel, w, dr, fl);
            frame_body(sel, w, dr, fl, 0, 0);
        end
    endtask

    initial begin
        q_model = '0;
        test_reset();
        test_left_div4();
        test_right_div1();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_reset_release();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
